// File: rtl/crg_pkg.sv
// Shared types and default constants for the clock/reset sequencer.
// Imported by crg_seq and its sub-modules.
package crg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SWITCH   = 3'd1,
    ST_WAIT_CLK = 3'd2,
    ST_EFUSE    = 3'd3,
    ST_FIFO_ON  = 3'd4,
    ST_RUN      = 3'd5,
    ST_DRAIN    = 3'd6
  } crg_seq_state_e;

  localparam int CRG_FIFO_LEAD = 4;
  localparam int CRG_SW_HOLD   = 1024;
  localparam int CRG_TMO_CYC   = 4096;
  localparam int CRG_CNT_W     = 12;

endpackage

// File: rtl/crg_seq_cnt.sv
// Loadable saturating down-counter with zero flag.
// Shared by switch hold, FIFO lead and wait timeout.
import crg_pkg::*;

module crg_seq_cnt #(
  parameter int W = CRG_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load wins over decrement; decrement stops at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sync_level.sv
// Multi-flop level synchroniser into the destination clock domain.
// Resets to 0.
module sync_level #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  // shift the asynchronous level through the flop chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ff <= '0;
    else          r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/crg_seq.sv
// Clock/reset enable sequencer in the always-on 6.5 MHz register domain.
// Optional wait-state timeout: define CRG_SEQ_TIMEOUT_EN.
import crg_pkg::*;

module crg_seq #(
  parameter int FIFO_LEAD = CRG_FIFO_LEAD,
  parameter int SW_HOLD   = CRG_SW_HOLD,
  parameter int TMO_CYC   = CRG_TMO_CYC
) (
  input  logic       clk_6p5m_reg,
  input  logic       rst_reg_n,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clk_sel_req,
  input  logic       efuse_done,
  input  logic       clk_en,
  input  logic       tim_run,
  output logic       rg_efuse_en,
  output logic       rg_fifo_clk_en,
  output logic       rg_top_start,
  output logic       rg_clk_sel,
  output logic       busy,
  output logic [2:0] seq_state,
  output logic       err_tmo
);

  localparam logic [CRG_CNT_W-1:0] LD_SW   = CRG_CNT_W'(SW_HOLD - 1);
  localparam logic [CRG_CNT_W-1:0] LD_FIFO = CRG_CNT_W'(FIFO_LEAD - 1);
  localparam logic [CRG_CNT_W-1:0] LD_TMO  = CRG_CNT_W'(TMO_CYC - 1);

  crg_seq_state_e r_state;
  crg_seq_state_e w_nxt;

  logic w_clk_en_s;
  logic w_tim_run_s;
  logic w_start;
  logic w_pend_set;
  logic w_pend_clr;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_busy_nxt;
  logic w_tmo;
  logic [CRG_CNT_W-1:0] w_load_val;

  logic r_pend;
  logic r_efuse_en;
  logic r_fifo_clk_en;
  logic r_top_start;
  logic r_clk_sel;
  logic r_busy;

  sync_level #(.STAGES(2)) u_sync_clk_en (
    .i_clk   (clk_6p5m_reg),
    .i_rst_n (rst_reg_n),
    .i_d     (clk_en),
    .o_q     (w_clk_en_s)
  );

  sync_level #(.STAGES(2)) u_sync_tim_run (
    .i_clk   (clk_6p5m_reg),
    .i_rst_n (rst_reg_n),
    .i_d     (tim_run),
    .o_q     (w_tim_run_s)
  );

  crg_seq_cnt #(.W(CRG_CNT_W)) u_cnt (
    .i_clk   (clk_6p5m_reg),
    .i_rst_n (rst_reg_n),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );

  // a simultaneous stop cancels a start
  assign w_start = start_req & ~stop_req;

  // next-state decode, pending-start control and timeout detect
  always_comb begin
    w_nxt      = r_state;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    w_tmo      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clk_sel_req != r_clk_sel) begin
          w_nxt      = ST_SWITCH;
          w_pend_set = w_start;
        end else if (w_start || r_pend) begin
          w_nxt      = ST_WAIT_CLK;
          w_pend_clr = 1'b1;
        end
      end
      ST_SWITCH: begin
        w_pend_set = w_start;
        if (w_zero) w_nxt = ST_IDLE;
      end
      ST_WAIT_CLK: begin
        if (stop_req)        w_nxt = ST_IDLE;
        else if (w_clk_en_s) w_nxt = ST_EFUSE;
      end
      ST_EFUSE: begin
        if (stop_req)        w_nxt = ST_IDLE;
        else if (efuse_done) w_nxt = ST_FIFO_ON;
      end
      ST_FIFO_ON: begin
        if (stop_req)    w_nxt = ST_IDLE;
        else if (w_zero) w_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_req) w_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_tim_run_s) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
`ifdef CRG_SEQ_TIMEOUT_EN
    if (w_zero &&
        (r_state == ST_WAIT_CLK ||
         r_state == ST_EFUSE ||
         r_state == ST_DRAIN ||
         (r_state == ST_RUN && !w_tim_run_s))) begin
      w_tmo = 1'b1;
      w_nxt = ST_IDLE;
    end
`endif
  end

  // counter reloads on every state change with the new state's budget
  always_comb begin
    w_load     = (w_nxt != r_state);
    w_load_val = '0;
    unique case (w_nxt)
      ST_SWITCH:  w_load_val = LD_SW;
      ST_FIFO_ON: w_load_val = LD_FIFO;
      ST_WAIT_CLK,
      ST_EFUSE,
      ST_RUN,
      ST_DRAIN:   w_load_val = LD_TMO;
      default:    w_load_val = '0;
    endcase
    w_dec = !w_load && !(r_state == ST_RUN && w_tim_run_s);
  end

  // busy drops only in IDLE and in an acknowledged RUN
  assign w_busy_nxt = (w_nxt != ST_IDLE) &&
                      !(w_nxt == ST_RUN && w_tim_run_s);

  // state, pending start and registered enables derived from next state
  always_ff @(posedge clk_6p5m_reg or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      r_state       <= ST_IDLE;
      r_pend        <= 1'b0;
      r_efuse_en    <= 1'b0;
      r_fifo_clk_en <= 1'b0;
      r_top_start   <= 1'b0;
      r_clk_sel     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      if (w_pend_set)      r_pend <= 1'b1;
      else if (w_pend_clr) r_pend <= 1'b0;
      r_efuse_en    <= (w_nxt == ST_EFUSE);
      r_fifo_clk_en <= (w_nxt == ST_FIFO_ON) ||
                       (w_nxt == ST_RUN) ||
                       (w_nxt == ST_DRAIN);
      r_top_start   <= (w_nxt == ST_RUN);
      if (w_nxt == ST_SWITCH && r_state != ST_SWITCH)
        r_clk_sel   <= clk_sel_req;
      r_busy        <= w_busy_nxt;
    end
  end

`ifdef CRG_SEQ_TIMEOUT_EN
  logic r_err;

  // sticky timeout flag; a later start request clears it
  always_ff @(posedge clk_6p5m_reg or negedge rst_reg_n) begin
    if (!rst_reg_n)     r_err <= 1'b0;
    else if (w_tmo)     r_err <= 1'b1;
    else if (start_req) r_err <= 1'b0;
  end

  assign err_tmo = r_err;
`else
  assign err_tmo = 1'b0;
`endif

  assign rg_efuse_en    = r_efuse_en;
  assign rg_fifo_clk_en = r_fifo_clk_en;
  assign rg_top_start   = r_top_start;
  assign rg_clk_sel     = r_clk_sel;
  assign busy           = r_busy;
  assign seq_state      = r_state;

endmodule
